// File: rtl/snes_bbus_pkg.sv
// Shared constants for the SNES B-bus port controller.
//  - register offsets within the 4-byte window
//  - STAT / CTRL bit positions
//  - 2-bit FSM state encodings
package snes_bbus_pkg;

    // Register offsets (addr[1:0] within the window)
    localparam logic [1:0] OFF_DATA = 2'd0;
    localparam logic [1:0] OFF_STAT = 2'd1;
    localparam logic [1:0] OFF_CTRL = 2'd2;
    localparam logic [1:0] OFF_ID   = 2'd3;

    // STAT register bits
    localparam int unsigned STAT_RX_VALID = 0;
    localparam int unsigned STAT_TX_READY = 1;
    localparam int unsigned STAT_TX_OFLOW = 2;
    localparam int unsigned STAT_RX_UFLOW = 3;

    // CTRL register bits
    localparam int unsigned CTRL_CLR_FLAGS = 0;
    localparam int unsigned CTRL_RX_FLUSH  = 1;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RD   = 2'b01;
    localparam logic [1:0] ST_WR   = 2'b10;

endpackage

// File: rtl/snes_strobe_sync.sv
// Synchroniser for the raw B-bus inputs into the clk domain.
//  Ports:
//   clk, rst_n            clock, async active-low reset
//   rd_n_raw, wr_n_raw    raw PARD_n / PAWR_n
//   addr_raw, data_raw    raw PA[7:0] / data bus
//   rd_n_s                synchronised PARD_n
//   addr_s, data_s        synchronised address / data
//   rd_fall, rd_rise      1-cycle edge pulses of synchronised PARD_n
//   wr_fall, wr_rise      1-cycle edge pulses of synchronised PAWR_n
//  All inputs travel through the same SYNC_STAGES flops so address and data stay aligned
//  with their strobe.
module snes_strobe_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rd_n_raw,
    input  logic       wr_n_raw,
    input  logic [7:0] addr_raw,
    input  logic [7:0] data_raw,
    output logic       rd_n_s,
    output logic [7:0] addr_s,
    output logic [7:0] data_s,
    output logic       rd_fall,
    output logic       rd_rise,
    output logic       wr_fall,
    output logic       wr_rise
);

    localparam int unsigned W = 18;

    logic [W-1:0] stage_q [SYNC_STAGES];
    logic         rd_prev_q;
    logic         wr_prev_q;
    logic         wr_n_s;

    // Strobes reset to "asserted" (0): a strobe still low when reset lifts produces no
    // falling edge, so an access interrupted by reset can never be picked up half-way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
            rd_prev_q <= 1'b0;
            wr_prev_q <= 1'b0;
        end else begin
            stage_q[0] <= {rd_n_raw, wr_n_raw, addr_raw, data_raw};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            rd_prev_q <= rd_n_s;
            wr_prev_q <= wr_n_s;
        end
    end

    assign rd_n_s = stage_q[SYNC_STAGES-1][17];
    assign wr_n_s = stage_q[SYNC_STAGES-1][16];
    assign addr_s = stage_q[SYNC_STAGES-1][15:8];
    assign data_s = stage_q[SYNC_STAGES-1][7:0];

    assign rd_fall = rd_prev_q & ~rd_n_s;
    assign rd_rise = ~rd_prev_q & rd_n_s;
    assign wr_fall = wr_prev_q & ~wr_n_s;
    assign wr_rise = ~wr_prev_q & wr_n_s;

endmodule

// File: rtl/snes_bbus_port_ctrl.sv
// SNES B-bus port window controller ($21FC-$21FF by default).
//  Bridges B-bus accesses to a host RX FIFO (host->SNES) and TX FIFO (SNES->host).
//  Ports:
//   clk, rst_n          board clock, async active-low reset
//   addr, data_in       raw B-bus address / data
//   data_out, data_oe   read data and pad output enable (window reads only)
//   PARD_n, PAWR_n      raw B-bus read / write strobes
//   rx_data, rx_valid   RX FIFO head / not-empty
//   rx_pop, rx_flush    1-cycle RX FIFO pop / flush
//   tx_data, tx_push    TX FIFO byte / 1-cycle push
//   tx_full             TX FIFO full
//  The read path is purely combinational from the raw bus; all state changes happen only
//  after the synchronised strobe release, so read contents stay stable for the strobe.
module snes_bbus_port_ctrl
    import snes_bbus_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR   = 8'hFC,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  ID_BYTE     = 8'h21
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic       PARD_n,
    input  logic       PAWR_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_pop,
    output logic       rx_flush,
    output logic [7:0] tx_data,
    output logic       tx_push,
    input  logic       tx_full
);

    localparam logic [5:0] WIN_TAG = BASE_ADDR[7:2];

    logic       rd_n_s;
    logic [7:0] addr_s;
    logic [7:0] data_s;
    logic       rd_fall, rd_rise, wr_fall, wr_rise;

    snes_strobe_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_n_raw (PARD_n),
        .wr_n_raw (PAWR_n),
        .addr_raw (addr),
        .data_raw (data_in),
        .rd_n_s   (rd_n_s),
        .addr_s   (addr_s),
        .data_s   (data_s),
        .rd_fall  (rd_fall),
        .rd_rise  (rd_rise),
        .wr_fall  (wr_fall),
        .wr_rise  (wr_rise)
    );

    logic [1:0] state_q, state_d;
    logic [1:0] off_q, off_d;
    logic [7:0] wr_sample_q, wr_sample_d;
    logic       rx_uflow_q, rx_uflow_d;
    logic       tx_oflow_q, tx_oflow_d;
    logic       rx_pop_q, rx_pop_d;
    logic       rx_flush_q, rx_flush_d;
    logic       tx_push_q, tx_push_d;
    logic [7:0] tx_data_q, tx_data_d;

    logic       hit_raw, hit_s;
    logic [7:0] stat_byte;
    logic [7:0] rd_mux;

    assign hit_raw = (addr[7:2] == WIN_TAG);
    assign hit_s   = (addr_s[7:2] == WIN_TAG);

    always_comb begin
        stat_byte                = 8'h00;
        stat_byte[STAT_RX_VALID] = rx_valid;
        stat_byte[STAT_TX_READY] = ~tx_full;
        stat_byte[STAT_TX_OFLOW] = tx_oflow_q;
        stat_byte[STAT_RX_UFLOW] = rx_uflow_q;
    end

    // Combinational read path straight off the raw bus to meet SNES read timing.
    always_comb begin
        rd_mux = 8'h00;
        case (addr[1:0])
            OFF_DATA: rd_mux = rx_valid ? rx_data : 8'h00;
            OFF_STAT: rd_mux = stat_byte;
            OFF_CTRL: rd_mux = 8'h00;
            OFF_ID:   rd_mux = ID_BYTE;
            default:  rd_mux = 8'h00;
        endcase
    end

    assign data_oe  = rst_n & ~PARD_n & hit_raw;
    assign data_out = data_oe ? rd_mux : 8'h00;

    always_comb begin
        logic uflow_set, oflow_set, flags_clr;
        uflow_set   = 1'b0;
        oflow_set   = 1'b0;
        flags_clr   = 1'b0;
        state_d     = state_q;
        off_d       = off_q;
        wr_sample_d = wr_sample_q;
        rx_pop_d    = 1'b0;
        rx_flush_d  = 1'b0;
        tx_push_d   = 1'b0;
        tx_data_d   = tx_data_q;

        case (state_q)
            ST_IDLE: begin
                if (rd_fall && hit_s) begin
                    state_d = ST_RD;
                    off_d   = addr_s[1:0];
                end else if (wr_fall && hit_s && rd_n_s) begin
                    // A write is only accepted while no read is in progress: read wins.
                    state_d     = ST_WR;
                    off_d       = addr_s[1:0];
                    wr_sample_d = data_s;
                end
            end
            ST_RD: begin
                if (rd_rise) begin
                    state_d = ST_IDLE;
                    case (off_q)
                        OFF_DATA: begin
                            if (rx_valid) rx_pop_d  = 1'b1;
                            else          uflow_set = 1'b1;
                        end
                        OFF_STAT: flags_clr = 1'b1;
                        default:  ;
                    endcase
                end
            end
            ST_WR: begin
                if (wr_rise) begin
                    // Commit the sample taken on the last cycle the strobe was still low.
                    state_d = ST_IDLE;
                    case (off_q)
                        OFF_DATA: begin
                            if (tx_full) begin
                                oflow_set = 1'b1;
                            end else begin
                                tx_push_d = 1'b1;
                                tx_data_d = wr_sample_q;
                            end
                        end
                        OFF_CTRL: begin
                            flags_clr  = wr_sample_q[CTRL_CLR_FLAGS];
                            rx_flush_d = wr_sample_q[CTRL_RX_FLUSH];
                        end
                        default: ;
                    endcase
                end else begin
                    wr_sample_d = data_s;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Set has priority over clear.
        rx_uflow_d = uflow_set | (rx_uflow_q & ~flags_clr);
        tx_oflow_d = oflow_set | (tx_oflow_q & ~flags_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            off_q       <= 2'd0;
            wr_sample_q <= 8'h00;
            rx_uflow_q  <= 1'b0;
            tx_oflow_q  <= 1'b0;
            rx_pop_q    <= 1'b0;
            rx_flush_q  <= 1'b0;
            tx_push_q   <= 1'b0;
            tx_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            wr_sample_q <= wr_sample_d;
            rx_uflow_q  <= rx_uflow_d;
            tx_oflow_q  <= tx_oflow_d;
            rx_pop_q    <= rx_pop_d;
            rx_flush_q  <= rx_flush_d;
            tx_push_q   <= tx_push_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign rx_pop   = rx_pop_q;
    assign rx_flush = rx_flush_q;
    assign tx_push  = tx_push_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_snes_bbus_port_ctrl.sv
// Directed bench for snes_bbus_port_ctrl: bus-cycle stimulus with hand-computed results.
module tb_snes_bbus_port_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       data_oe;
    logic       PARD_n = 1'b1;
    logic       PAWR_n = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_pop;
    logic       rx_flush;
    logic [7:0] tx_data;
    logic       tx_push;
    logic       tx_full = 1'b0;

    int nchk = 0;
    int npass = 0;

    int pop_cnt = 0;
    int push_cnt = 0;
    int flush_cnt = 0;

    snes_bbus_port_ctrl #(
        .BASE_ADDR   (8'hFC),
        .SYNC_STAGES (2),
        .ID_BYTE     (8'h21)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .data_oe  (data_oe),
        .PARD_n   (PARD_n),
        .PAWR_n   (PAWR_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_pop   (rx_pop),
        .rx_flush (rx_flush),
        .tx_data  (tx_data),
        .tx_push  (tx_push),
        .tx_full  (tx_full)
    );

    always #5 clk = ~clk;

    // Pulse counters: each counts clock cycles the output is high.
    always @(posedge clk) begin
        if (rx_pop === 1'b1)   pop_cnt   <= pop_cnt + 1;
        if (tx_push === 1'b1)  push_cnt  <= push_cnt + 1;
        if (rx_flush === 1'b1) flush_cnt <= flush_cnt + 1;
    end

    // Drive one read strobe; returns data_out/data_oe sampled mid-strobe.
    task automatic bus_read(input logic [7:0] a, output logic [7:0] d, output logic oe);
        @(negedge clk);
        addr   = a;
        PARD_n = 1'b0;
        repeat (4) @(negedge clk);
        d  = data_out;
        oe = data_oe;
        PARD_n = 1'b1;
        repeat (6) @(negedge clk);
        addr = 8'h00;
    endtask

    // Drive one write strobe; data changes from 'first' to 'last' while the strobe is low.
    task automatic bus_write(input logic [7:0] a, input logic [7:0] first, input logic [7:0] last);
        @(negedge clk);
        addr    = a;
        data_in = first;
        PAWR_n  = 1'b0;
        repeat (3) @(negedge clk);
        data_in = last;
        repeat (4) @(negedge clk);
        PAWR_n = 1'b1;
        repeat (6) @(negedge clk);
        addr    = 8'h00;
        data_in = 8'h00;
    endtask

    task automatic test_reset;
        logic [7:0] d;
        logic       oe;
        int         p0, q0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        nchk++; if (data_oe !== 1'b0) $display("FAIL rst_oe: got %b want 0", data_oe); else npass++;
        nchk++; if (data_out !== 8'h00) $display("FAIL rst_dout: got %h want 00", data_out); else npass++;
        nchk++; if ({rx_pop, rx_flush, tx_push} !== 3'b000)
            $display("FAIL rst_pulses: got %b want 000", {rx_pop, rx_flush, tx_push});
        else npass++;
        nchk++; if (tx_data !== 8'h00) $display("FAIL rst_txdata: got %h want 00", tx_data); else npass++;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        p0 = pop_cnt; q0 = push_cnt;
        bus_read(8'hFF, d, oe);
        nchk++; if (oe !== 1'b1) $display("FAIL id_oe: got %b want 1", oe); else npass++;
        nchk++; if (d !== 8'h21) $display("FAIL id_data: got %h want 21", d); else npass++;
        nchk++; if (pop_cnt - p0 != 0 || push_cnt - q0 != 0)
            $display("FAIL id_side_effect: pops %0d pushes %0d want 0 0", pop_cnt - p0, push_cnt - q0);
        else npass++;
    endtask

    task automatic test_data_read;
        int p0;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        p0 = pop_cnt;
        @(negedge clk);
        addr   = 8'hFC;
        PARD_n = 1'b0;
        repeat (4) @(negedge clk);
        nchk++; if (data_out !== 8'hA5) $display("FAIL data_rd: got %h want a5", data_out); else npass++;
        PARD_n = 1'b1;
        // Released at a negedge: pop must appear after the third following posedge.
        repeat (2) @(posedge clk);
        #1;
        nchk++; if (rx_pop !== 1'b0) $display("FAIL pop_early: got %b want 0", rx_pop); else npass++;
        @(posedge clk);
        #1;
        nchk++; if (rx_pop !== 1'b1) $display("FAIL pop_latency: got %b want 1", rx_pop); else npass++;
        @(posedge clk);
        #1;
        nchk++; if (rx_pop !== 1'b0) $display("FAIL pop_width: got %b want 0", rx_pop); else npass++;
        repeat (4) @(negedge clk);
        addr = 8'h00;
        nchk++; if (pop_cnt - p0 != 1) $display("FAIL pop_count: got %0d want 1", pop_cnt - p0);
        else npass++;
    endtask

    task automatic test_underflow;
        logic [7:0] d;
        logic       oe;
        int         p0;
        rx_valid = 1'b0;
        p0 = pop_cnt;
        bus_read(8'hFC, d, oe);
        nchk++; if (d !== 8'h00 || oe !== 1'b1)
            $display("FAIL empty_rd: got %h/%b want 00/1", d, oe);
        else npass++;
        nchk++; if (pop_cnt != p0) $display("FAIL empty_nopop: got %0d want 0", pop_cnt - p0);
        else npass++;
        bus_read(8'hFD, d, oe);
        nchk++; if (d !== 8'h0A) $display("FAIL stat_uflow: got %h want 0a", d); else npass++;
        bus_read(8'hFD, d, oe);
        nchk++; if (d !== 8'h02) $display("FAIL stat_cleared: got %h want 02", d); else npass++;
    endtask

    task automatic test_tx_write;
        logic [7:0] d;
        logic       oe;
        int         q0;
        tx_full = 1'b0;
        q0 = push_cnt;
        bus_write(8'hFC, 8'h11, 8'h3C);
        nchk++; if (push_cnt - q0 != 1) $display("FAIL tx_push: got %0d want 1", push_cnt - q0);
        else npass++;
        nchk++; if (tx_data !== 8'h3C) $display("FAIL tx_data: got %h want 3c", tx_data); else npass++;
        tx_full = 1'b1;
        q0 = push_cnt;
        bus_write(8'hFC, 8'h55, 8'h55);
        nchk++; if (push_cnt != q0) $display("FAIL tx_full_push: got %0d want 0", push_cnt - q0);
        else npass++;
        nchk++; if (tx_data !== 8'h3C) $display("FAIL tx_full_data: got %h want 3c", tx_data);
        else npass++;
        bus_read(8'hFD, d, oe);
        nchk++; if (d !== 8'h04) $display("FAIL stat_oflow: got %h want 04", d); else npass++;
        tx_full = 1'b0;
    endtask

    task automatic test_ctrl;
        logic [7:0] d;
        logic       oe;
        int         f0;
        f0 = flush_cnt;
        bus_write(8'hFE, 8'h02, 8'h02);
        nchk++; if (flush_cnt - f0 != 1) $display("FAIL flush: got %0d want 1", flush_cnt - f0);
        else npass++;
        bus_read(8'hFE, d, oe);
        nchk++; if (d !== 8'h00 || oe !== 1'b1) $display("FAIL ctrl_rd: got %h/%b want 00/1", d, oe);
        else npass++;
        rx_valid = 1'b0;
        bus_read(8'hFC, d, oe);
        f0 = flush_cnt;
        bus_write(8'hFE, 8'h01, 8'h01);
        nchk++; if (flush_cnt != f0) $display("FAIL clr_noflush: got %0d want 0", flush_cnt - f0);
        else npass++;
        bus_read(8'hFD, d, oe);
        nchk++; if (d !== 8'h02) $display("FAIL ctrl_clr: got %h want 02", d); else npass++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] d;
        logic       oe;
        int         p0;
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        p0 = pop_cnt;
        bus_read(8'hFC, d, oe);
        bus_read(8'hFC, d, oe);
        nchk++; if (pop_cnt - p0 != 2) $display("FAIL b2b_pops: got %0d want 2", pop_cnt - p0);
        else npass++;
        nchk++; if (d !== 8'h5A) $display("FAIL b2b_data: got %h want 5a", d); else npass++;
    endtask

    task automatic test_reset_abort;
        logic [7:0] d;
        logic       oe;
        int         p0;
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        p0 = pop_cnt;
        @(negedge clk);
        addr   = 8'hFC;
        PARD_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        nchk++; if (data_oe !== 1'b0) $display("FAIL abort_oe: got %b want 0", data_oe); else npass++;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        PARD_n = 1'b1;
        repeat (8) @(negedge clk);
        addr = 8'h00;
        nchk++; if (pop_cnt != p0) $display("FAIL abort_pop: got %0d want 0", pop_cnt - p0);
        else npass++;
        bus_read(8'hF0, d, oe);
        nchk++; if (oe !== 1'b0 || d !== 8'h00)
            $display("FAIL miss_rd: got %h/%b want 00/0", d, oe);
        else npass++;
        nchk++; if (pop_cnt != p0) $display("FAIL miss_pop: got %0d want 0", pop_cnt - p0);
        else npass++;
    endtask

    initial begin
        test_reset();
        test_data_read();
        test_underflow();
        test_tx_write();
        test_ctrl();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
